// File: rtl/test_pattern_generator.sv
// ---------------------------------------------------------------------------
// test_pattern_generator
//   Free-running raster timing generator with nine selectable test patterns.
//   It is the reference video source ahead of the delay pipeline. A new
//   pattern is picked up only on a frame boundary, so the output never tears.
//
// Ports
//   clk            pixel clock
//   reset          asynchronous, active-high reset
//   pattern        requested pattern index (0-8 valid, 9-15 render black)
//   hsync, vsync   sync outputs, polarity set by SYNC_ACTIVE_HIGH
//   de             data enable, high on active pixels
//   rgb            {R,G,B} pixel, forced to 0 whenever de=0
//   frame_start    one-cycle pulse on the output cycle of pixel (0,0)
//   active_pattern pattern being rendered in the current frame
//
// All outputs are registered from the current (h,v) and active_pattern, so
// they lag the counters by exactly one cycle and stay mutually aligned.
// ---------------------------------------------------------------------------
module test_pattern_generator #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FP             = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BP             = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FP             = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BP             = 33,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int RAMP_SHIFT       = 2,
  parameter int CHECK_LOG2       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  pattern,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start,
  output logic [3:0]  active_pattern
);

  // -------------------------------------------------------------------------
  // Timing constants, all sized to the 12-bit counters
  // -------------------------------------------------------------------------
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] H_TOTAL_M1 = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] V_TOTAL_M1 = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [11:0] LINE_MAX   = 12'(H_ACTIVE - 1);
  localparam logic [11:0] BAR_W_M1   = 12'(H_ACTIVE / 8 - 1);

  localparam logic        SYNC_ON    = (SYNC_ACTIVE_HIGH != 0);
  localparam logic [3:0]  RST_PAT    = 4'd4;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [11:0] r_h;
  logic [11:0] r_v;
  logic [11:0] r_line_pos;
  logic [11:0] r_bar_cnt;     // pixel offset inside the current colour bar
  logic [2:0]  r_bar_idx;     // colour bar index for the current h
  logic [3:0]  r_active_pattern;

  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic [23:0] r_rgb;
  logic        r_frame_start;

  // -------------------------------------------------------------------------
  // Decode of the current counter position
  // -------------------------------------------------------------------------
  logic        w_h_end;
  logic        w_v_end;
  logic        w_frame_end;
  logic        w_active;
  logic        w_hs_on;
  logic        w_vs_on;
  logic [11:0] w_ramp;
  logic        w_check;
  logic [23:0] w_bar_rgb;
  logic [23:0] w_pix;
  logic [23:0] w_rgb;

  assign w_h_end     = (r_h == H_TOTAL_M1);
  assign w_v_end     = (r_v == V_TOTAL_M1);
  assign w_frame_end = w_h_end && w_v_end;
  assign w_active    = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_on     = (r_h >= HS_START) && (r_h < HS_END);
  assign w_vs_on     = (r_v >= VS_START) && (r_v < VS_END);
  assign w_ramp      = r_h >> RAMP_SHIFT;
  assign w_check     = r_h[CHECK_LOG2] ^ r_v[CHECK_LOG2];

  always_comb begin
    w_bar_rgb = 24'h000000;
    case (r_bar_idx)
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      3'd5:    w_bar_rgb = 24'hFF0000;
      3'd6:    w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    w_pix = 24'h000000;
    case (r_active_pattern)
      4'd0:    w_pix = 24'h000000;
      4'd1:    w_pix = 24'hFFFFFF;
      4'd2:    w_pix = 24'hFF0000;
      4'd3:    w_pix = 24'h00FF00;
      4'd4:    w_pix = 24'h0000FF;
      4'd5:    w_pix = w_bar_rgb;
      4'd6:    w_pix = {w_ramp[7:0], w_ramp[7:0], w_ramp[7:0]};
      4'd7:    w_pix = w_check ? 24'hFFFFFF : 24'h000000;
      4'd8:    w_pix = (r_h == r_line_pos) ? 24'hFFFFFF : 24'h000000;
      default: w_pix = 24'h000000;
    endcase
  end

  // Blanking is always black regardless of the pattern.
  assign w_rgb = w_active ? w_pix : 24'h000000;

  // -------------------------------------------------------------------------
  // Raster counters, bar tracker, frame-boundary pattern latch
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h              <= '0;
      r_v              <= '0;
      r_line_pos       <= '0;
      r_bar_cnt        <= '0;
      r_bar_idx        <= '0;
      r_active_pattern <= RST_PAT;
    end else begin
      if (w_h_end) begin
        r_h <= '0;
        r_v <= w_v_end ? 12'd0 : r_v + 12'd1;
      end else begin
        r_h <= r_h + 12'd1;
      end

      // The bar index follows h without a divider: count pixels within a
      // bar and step the index at each bar width, saturating at the last bar
      // so any remainder pixels of a non-multiple-of-8 width stay in bar 7.
      if (w_h_end) begin
        r_bar_cnt <= '0;
        r_bar_idx <= '0;
      end else if (r_h < H_ACT) begin
        if (r_bar_cnt == BAR_W_M1) begin
          r_bar_cnt <= '0;
          if (r_bar_idx != 3'd7)
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
          r_bar_cnt <= r_bar_cnt + 12'd1;
        end
      end

      // Pattern select and moving-line position both advance on the last
      // pixel of the frame, so the new values apply from pixel (0,0).
      if (w_frame_end) begin
        r_active_pattern <= pattern;
        r_line_pos       <= (r_line_pos == LINE_MAX) ? 12'd0 : r_line_pos + 12'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync       <= ~SYNC_ON;
      r_vsync       <= ~SYNC_ON;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_hs_on ? SYNC_ON : ~SYNC_ON;
      r_vsync       <= w_vs_on ? SYNC_ON : ~SYNC_ON;
      r_de          <= w_active;
      r_rgb         <= w_rgb;
      r_frame_start <= (r_h == 12'd0) && (r_v == 12'd0);
    end
  end

  assign hsync          = r_hsync;
  assign vsync          = r_vsync;
  assign de             = r_de;
  assign rgb            = r_rgb;
  assign frame_start    = r_frame_start;
  assign active_pattern = r_active_pattern;

endmodule

// File: tb/tb_test_pattern_generator.sv
// ---------------------------------------------------------------------------
// tb_test_pattern_generator
//   Directed bench on a reduced raster so many frames fit in a short run:
//   H 32/2/4/2 (total 40), V 8/1/2/1 (total 12), frame = 480 cycles.
//   Bars are 4 pixels wide, checker squares are 4x4, ramp shift is 2.
//   cyc counts rising edges since reset release; the outputs seen after
//   edge n belong to raster pixel n-1, so pixel (f,y,x) appears after edge
//   f*480 + y*40 + x + 1.
// ---------------------------------------------------------------------------
module tb_test_pattern_generator;

  localparam int HT = 40;
  localparam int VT = 12;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  pattern = 4'd1;
  logic        hsync, vsync, de, frame_start;
  logic [23:0] rgb;
  logic [3:0]  active_pattern;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int de_cnt, hs_cnt, vs_cnt, fs_cnt, last_fs, fs_gap;

  test_pattern_generator #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_ACTIVE_HIGH(0), .RAMP_SHIFT(2), .CHECK_LOG2(2)
  ) dut (
    .clk(clk), .reset(reset), .pattern(pattern),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .frame_start(frame_start), .active_pattern(active_pattern)
  );

  always #5 clk = ~clk;

  function automatic int pix(input int f, input int y, input int x);
    return f * FT + y * HT + x + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
  endtask

  // Advance to edge 'target', sampling 1ns after each edge and accumulating
  // output activity counts.
  task automatic run_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
      de_cnt += int'(de);
      hs_cnt += int'(!hsync);
      vs_cnt += int'(!vsync);
      if (frame_start) begin
        fs_cnt++;
        fs_gap  = cyc - last_fs;
        last_fs = cyc;
      end
    end
  endtask

  initial begin
    last_fs = 0; fs_gap = 0;
    clr_cnt();

    // ---- reset state
    #12;
    chk("rst_de",     32'(de), 32'h0);
    chk("rst_rgb",    32'(rgb), 32'h0);
    chk("rst_fs",     32'(frame_start), 32'h0);
    chk("rst_hsync",  32'(hsync), 32'h1);
    chk("rst_vsync",  32'(vsync), 32'h1);
    chk("rst_apat",   32'(active_pattern), 32'h4);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;

    // ---- first line: timing and default pattern 4
    run_to(1);
    chk("l0_de_first", 32'(de), 32'h1);
    chk("l0_fs_first", 32'(frame_start), 32'h1);
    chk("l0_rgb_p4",   32'(rgb), 32'h0000FF);
    run_to(32);
    chk("l0_de_x31",   32'(de), 32'h1);
    run_to(33);
    chk("l0_de_x32",   32'(de), 32'h0);
    chk("l0_rgb_blank", 32'(rgb), 32'h0);
    run_to(34);
    chk("l0_hs_x33",   32'(hsync), 32'h1);
    run_to(35);
    chk("l0_hs_x34",   32'(hsync), 32'h0);
    run_to(38);
    chk("l0_hs_x37",   32'(hsync), 32'h0);
    run_to(39);
    chk("l0_hs_x38",   32'(hsync), 32'h1);
    run_to(40);
    chk("l0_de_count", 32'(de_cnt), 32'd32);
    chk("l0_hs_count", 32'(hs_cnt), 32'd4);
    chk("l0_fs_count", 32'(fs_cnt), 32'd1);

    // ---- rest of frame 0: vertical timing, de only in active lines
    clr_cnt();
    run_to(pix(0, 8, 39));
    chk("f0_vs_line8", 32'(vsync), 32'h1);
    run_to(pix(0, 9, 0));
    chk("f0_vs_line9", 32'(vsync), 32'h0);
    run_to(pix(0, 10, 39));
    chk("f0_vs_line10", 32'(vsync), 32'h0);
    run_to(pix(0, 11, 0));
    chk("f0_vs_line11", 32'(vsync), 32'h1);
    run_to(FT);
    chk("f0_de_count", 32'(de_cnt), 32'd224);
    chk("f0_vs_count", 32'(vs_cnt), 32'd80);
    chk("f0_fs_none",  32'(fs_cnt), 32'd0);
    chk("f0_apat_end", 32'(active_pattern), 32'h1);

    // ---- frame 1: pattern 1 takes effect, mid-frame change ignored
    run_to(pix(1, 0, 0));
    chk("f1_fs",       32'(frame_start), 32'h1);
    chk("f1_fs_gap",   32'(fs_gap), 32'(FT));
    chk("f1_rgb_p1",   32'(rgb), 32'hFFFFFF);
    run_to(pix(1, 4, 0));
    pattern = 4'd3;
    run_to(pix(1, 5, 3));
    chk("f1_mid_rgb",  32'(rgb), 32'hFFFFFF);
    run_to(pix(1, 7, 31));
    chk("f1_end_rgb",  32'(rgb), 32'hFFFFFF);
    chk("f1_end_apat", 32'(active_pattern), 32'h1);
    run_to(pix(2, 0, 0));
    chk("f2_fs_gap",   32'(fs_gap), 32'(FT));
    chk("f2_rgb_p3",   32'(rgb), 32'h00FF00);
    chk("f2_apat",     32'(active_pattern), 32'h3);
    pattern = 4'd5;

    // ---- frame 3: colour bars, 4 pixels each
    run_to(pix(3, 0, 0));
    chk("bar_x0",  32'(rgb), 32'hFFFFFF);
    run_to(pix(3, 0, 3));
    chk("bar_x3",  32'(rgb), 32'hFFFFFF);
    run_to(pix(3, 0, 4));
    chk("bar_x4",  32'(rgb), 32'hFFFF00);
    run_to(pix(3, 0, 8));
    chk("bar_x8",  32'(rgb), 32'h00FFFF);
    run_to(pix(3, 0, 31));
    chk("bar_x31", 32'(rgb), 32'h000000);
    run_to(pix(3, 1, 4));
    chk("bar_y1_x4", 32'(rgb), 32'hFFFF00);
    run_to(pix(3, 1, 22));
    chk("bar_y1_x22", 32'(rgb), 32'hFF0000);
    pattern = 4'd7;

    // ---- frame 4: checkerboard, 4x4 squares
    run_to(pix(4, 0, 3));
    chk("chk_3_0", 32'(rgb), 32'h000000);
    run_to(pix(4, 0, 4));
    chk("chk_4_0", 32'(rgb), 32'hFFFFFF);
    run_to(pix(4, 4, 0));
    chk("chk_0_4", 32'(rgb), 32'hFFFFFF);
    run_to(pix(4, 4, 4));
    chk("chk_4_4", 32'(rgb), 32'h000000);
    pattern = 4'd6;

    // ---- frame 5: grey ramp, g = x>>2
    run_to(pix(5, 2, 13));
    chk("ramp_x13", 32'(rgb), 32'h030303);
    run_to(pix(5, 2, 31));
    chk("ramp_x31", 32'(rgb), 32'h070707);
    pattern = 4'd12;

    // ---- frame 6: undefined index renders black, timing unchanged
    run_to(pix(6, 0, 0));
    chk("p12_fs",  32'(frame_start), 32'h1);
    chk("p12_de",  32'(de), 32'h1);
    chk("p12_rgb", 32'(rgb), 32'h000000);
    run_to(pix(6, 3, 5));
    chk("p12_rgb_mid", 32'(rgb), 32'h000000);
    pattern = 4'd8;

    // ---- frames 7..33: moving line at x = frame mod 32
    run_to(pix(7, 0, 6));
    chk("ml_f7_x6", 32'(rgb), 32'h000000);
    run_to(pix(7, 0, 7));
    chk("ml_f7_x7", 32'(rgb), 32'hFFFFFF);
    run_to(pix(7, 0, 8));
    chk("ml_f7_x8", 32'(rgb), 32'h000000);
    run_to(pix(7, 5, 7));
    chk("ml_f7_y5", 32'(rgb), 32'hFFFFFF);
    run_to(pix(31, 0, 31));
    chk("ml_f31_x31", 32'(rgb), 32'hFFFFFF);
    run_to(pix(32, 0, 0));
    chk("ml_f32_x0", 32'(rgb), 32'hFFFFFF);
    run_to(pix(32, 0, 31));
    chk("ml_f32_x31", 32'(rgb), 32'h000000);
    run_to(pix(33, 0, 0));
    chk("ml_f33_x0", 32'(rgb), 32'h000000);
    run_to(pix(33, 0, 1));
    chk("ml_f33_x1", 32'(rgb), 32'hFFFFFF);
    pattern = 4'd6;

    // ---- frame 34: asynchronous reset mid-line, mid-frame
    run_to(pix(34, 5, 20));
    chk("pre_rst_rgb",  32'(rgb), 32'h050505);
    chk("pre_rst_apat", 32'(active_pattern), 32'h6);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_de",    32'(de), 32'h0);
    chk("arst_rgb",   32'(rgb), 32'h0);
    chk("arst_fs",    32'(frame_start), 32'h0);
    chk("arst_hsync", 32'(hsync), 32'h1);
    chk("arst_vsync", 32'(vsync), 32'h1);
    chk("arst_apat",  32'(active_pattern), 32'h4);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    run_to(1);
    chk("post_fs",   32'(frame_start), 32'h1);
    chk("post_de",   32'(de), 32'h1);
    chk("post_rgb",  32'(rgb), 32'h0000FF);
    chk("post_apat", 32'(active_pattern), 32'h4);
    run_to(pix(0, 0, 20));
    chk("post_rgb_x20", 32'(rgb), 32'h0000FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
